port_out_queue: RTL
===================

# port_out_queue

Output-port drain queue sitting directly downstream of the P0 output register. Each time the controller latches a word into P0, the word is captured into a small FIFO. It is then presented to an external consumer over a valid/ready handshake, with a programmable minimum gap between transfers. This decouples the single-cycle bus write from a slow external device so no P0 write is lost while the consumer stalls.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- WIDTH, 16, data width; matches the bus width
- GAP, 0, idle cycles forced after each completed transfer; 0..15
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- wr_en  input  1  one-cycle strobe, high in the cycle P0 latches a bus word
- wr_data  input  WIDTH  word being latched into P0
- out_data  output  WIDTH  head-of-queue word
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready at a rising edge
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  $clog2(DEPTH)+1  occupied entries
- ovf  output  1  sticky overflow flag (see Configuration)
- ovf_clr  input  1  clears ovf

## Operation
- Storage: DEPTH x WIDTH register array, wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH. count is a separate register.
- Push: wr_en && !full stores wr_data at wr_ptr, increments wr_ptr and count.
- Dropped write: wr_en && full discards the word. This applies even if a pop occurs in the same cycle. Pointers and count are unchanged by the push.
- Pop: a transfer increments rd_ptr and decrements count.
- Simultaneous push and pop when not full: both take effect and count is unchanged.
- Drain FSM states:
  - IDLE: out_valid=0. Moves to PRESENT when count != 0.
  - PRESENT: out_valid=1, out_data=mem[rd_ptr]. On a transfer it moves to GAP if GAP>0. Otherwise it stays in PRESENT if count after the pop is nonzero, else moves to IDLE.
  - GAP: out_valid=0. A gap counter loads GAP-1 on entry and decrements each cycle. At 0 the FSM moves to PRESENT if count != 0, else to IDLE.
- out_data is held stable while out_valid && !out_ready. out_valid never drops without a transfer.
- Pushes are accepted in every state.

## Timing
- Reset values: out_valid=0, out_data=0, full=0, empty=1, count=0, ovf=0, FSM=IDLE, pointers=0, gap counter=0. Storage array contents are not reset.
- Reset asserted mid-transfer flushes all entries immediately; no handshake completes.
- Latency, empty queue to first presentation: wr_en in cycle N gives out_valid=1 in cycle N+2. The push lands at edge N, and IDLE->PRESENT happens at edge N+1.
- Back-to-back throughput with GAP=0 is one word per cycle.
- With GAP=g, the interval between consecutive transfers is at least g+1 cycles.
- full, empty and count are registered and reflect all pushes and pops up to the previous edge.
- out_data is a combinational read of mem[rd_ptr], gated to 0 when out_valid=0.

## Configuration
- PORT_OUT_QUEUE_OVF_EN defined:
  - ovf sets at the edge after any dropped write and stays set.
  - ovf_clr clears it at the next edge.
  - If ovf_clr and a drop occur in the same cycle, set wins.
- PORT_OUT_QUEUE_OVF_EN undefined: ovf is tied to 0, ovf_clr is ignored, and no flag register exists.

## Structure
- Shared package port_pkg holds:
  - the drain-state encoding (IDLE=2'd0, PRESENT=2'd1, GAP=2'd2)
  - the default DEPTH, WIDTH and GAP values
- One sub-module, port_fifo_mem: the storage array plus pointer and count logic, exposing push, pop, full, empty, count and head data.
- The drain FSM, gap counter and ovf flag live in port_out_queue.

## Test plan
- Reset, then wr_en with 16'hA5A5 in cycle 3 -> out_valid high in cycle 5 with out_data=16'hA5A5; out_ready=1 then gives empty=1 one cycle later.
- Push 16'h0001..16'h0004 back-to-back (DEPTH=4, GAP=0) with out_ready=0 -> full=1 and count=4. Then out_ready=1 -> words appear in order, one per cycle.
- Full queue, then wr_en with 16'hDEAD and a pop in the same cycle -> 16'hDEAD is not in the output stream and count=3. With the macro defined, ovf=1 and ovf_clr drops it one cycle later.
- GAP=3, queue holds 3 words, out_ready held high -> transfers occur exactly 4 cycles apart, with out_valid low in each gap.
- out_ready low for 10 cycles while presenting 16'h1234 -> out_valid and out_data stay stable; the transfer completes on the first edge with out_ready high.
- Assert rst with 2 words queued during PRESENT -> out_valid=0, count=0 and empty=1 immediately. After release, a fresh push presents only the new word.

Source files
------------

// File: rtl/port_pkg.sv
// Shared definitions for the P0 output-port drain queue: drain-state encoding
// and default geometry.
package port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } drain_state_e;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_GAP   = 0;

endpackage

// File: rtl/port_fifo_mem.sv
// Storage array with wrap-around pointers and an explicit occupancy counter.
// full/empty/count are registered; head data is a combinational read.
module port_fifo_mem
  import port_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A push into a full queue is dropped even when a pop frees a slot this cycle
  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    count_next_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointer, counter and status flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_W'(DEPTH));
      empty_r <= (count_next_s == {CNT_W{1'b0}});
    end
  end

  // Storage array write port, intentionally not reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;
  assign count     = count_r;

endmodule

// File: rtl/port_out_queue.sv
// P0 output-port drain queue: captures every P0 write and drains it over a
// valid/ready handshake with a minimum inter-transfer gap. Optional sticky
// overflow flag enabled by defining PORT_OUT_QUEUE_OVF_EN.
module port_out_queue
  import port_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int         CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  drain_state_e     state_r;
  drain_state_e     state_next_s;
  logic [3:0]       gap_cnt_r;
  logic [3:0]       gap_cnt_next_s;
  logic [WIDTH-1:0] head_s;
  logic             xfer_s;
  logic             push_s;
  logic             drop_s;
  logic             remain_s;

  port_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (xfer_s),
    .head_data (head_s),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign xfer_s   = (state_r == ST_PRESENT) && out_ready;
  assign push_s   = wr_en && !full;
  assign drop_s   = wr_en && full;
  // Occupancy after this edge is nonzero unless the last word leaves with no refill
  assign remain_s = (count != CNT_W'(1)) || push_s;

  // Drain FSM next-state and gap counter reload/decrement
  always_comb begin
    state_next_s   = state_r;
    gap_cnt_next_s = gap_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (count != {CNT_W{1'b0}}) begin
          state_next_s = ST_PRESENT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (xfer_s) begin
          if (GAP > 0) begin
            state_next_s   = ST_GAP;
            gap_cnt_next_s = GAP_LOAD;
          end else if (remain_s) begin
            state_next_s = ST_PRESENT;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_PRESENT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 4'd0) begin
          if (count != {CNT_W{1'b0}}) begin
            state_next_s = ST_PRESENT;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          gap_cnt_next_s = gap_cnt_r - 4'd1;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        gap_cnt_next_s = 4'd0;
      end
    endcase
  end

  // Drain FSM state and gap counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      gap_cnt_r <= 4'd0;
    end else begin
      state_r   <= state_next_s;
      gap_cnt_r <= gap_cnt_next_s;
    end
  end

  assign out_valid = (state_r == ST_PRESENT);
  assign out_data  = out_valid ? head_s : {WIDTH{1'b0}};

`ifdef PORT_OUT_QUEUE_OVF_EN
  logic ovf_r;

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  assign ovf = ovf_r;
`else
  logic unused_ovf_s;

  assign unused_ovf_s = ovf_clr ^ drop_s;
  assign ovf          = 1'b0;
`endif

endmodule
